// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute stage: ALUSel codes and datapath widths.
package alu_exec_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_COPY1 = 4'd10
  } alu_sel_e;

  // Any ALUSel code at or above this value is undefined.
  localparam logic [3:0] ILLEGAL_SEL = 4'd11;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational RV32I ALU datapath; undefined select codes yield 0 and flag illegal.
module alu_exec_stage_alu
  import alu_exec_stage_pkg::*;
(
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [3:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  logic [4:0] shamt;

  assign shamt   = op2[4:0];
  assign illegal = (sel >= ILLEGAL_SEL);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD:   result = op1 + op2;
      ALU_SUB:   result = op1 - op2;
      ALU_AND:   result = op1 & op2;
      ALU_OR:    result = op1 | op2;
      ALU_XOR:   result = op1 ^ op2;
      ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      ALU_SLL:   result = op1 << shamt;
      ALU_SRL:   result = op1 >> shamt;
      ALU_SRA:   result = $signed(op1) >>> shamt;
      ALU_COPY1: result = op1;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU plus a 2-entry result buffer with valid/ready on both sides.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [3:0]        in_sel,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic              out_illegal,
  output logic [31:0]       retired
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              illegal;
    logic              wen;
  } entry_t;

  entry_t            entries_q [2];
  entry_t            new_entry;
  logic              head_q;
  logic              tail;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;

  alu_exec_stage_alu u_alu (
    .op1     (in_op1),
    .op2     (in_op2),
    .sel     (in_sel),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign new_entry.data    = alu_result;
  assign new_entry.rd      = in_rd;
  assign new_entry.illegal = alu_illegal;
  assign new_entry.wen     = (in_rd != '0) && !alu_illegal;

  // in_ready depends only on registered count, keeping out_ready off the upstream path.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign tail      = head_q ^ (count_q == 2'd1);

  assign out_data    = entries_q[head_q].data;
  assign out_rd      = entries_q[head_q].rd;
  assign out_wen     = entries_q[head_q].wen;
  assign out_illegal = entries_q[head_q].illegal;

  // NOTE: the two entries are reset explicitly because out_* must read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q[0] <= '0;
      entries_q[1] <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
      retired      <= '0;
    end else begin
      if (push) begin
        entries_q[tail] <= new_entry;
      end
      if (pop) begin
        head_q  <= ~head_q;
        retired <= retired + 32'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and streaming checks of alu_exec_stage against hand-computed values and a small model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [3:0]  in_sel;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic [31:0] retired;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_retired = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_stage #(.RD_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .in_sel      (in_sel),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_illegal (out_illegal),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int          sh;
    sh = int'(b[4:0]);
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a + (~b) + 32'd1;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd6:    r = {31'd0, (a < b)};
      4'd7:    r = a << sh;
      4'd8:    r = a >> sh;
      4'd9: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      end
      4'd10:   r = a;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1;
    in_sel   = sel;
    in_op1   = a;
    in_op2   = b;
    in_rd    = rd;
  endtask

  // One op with out_ready high: pushed on the next edge, checked, then popped on the following edge.
  task automatic single_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_data, input logic exp_wen,
                           input logic exp_ill);
    @(negedge clk);
    out_ready = 1'b1;
    drive(sel, a, b, rd);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_wen"}, {31'd0, out_wen}, {31'd0, exp_wen});
    check({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    exp_retired++;
    @(negedge clk);
    check({tag, "_retired"}, retired, exp_retired);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    in_sel    = '0;
    in_rd     = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_retired", retired, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst = 1'b0;

    // Single ADD: latency 1, then popped.
    @(negedge clk);
    out_ready = 1'b1;
    drive(4'd0, 32'd7, 32'd5, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_data", out_data, 32'd12);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    check("add_wen", {31'd0, out_wen}, 32'd1);
    exp_retired++;
    @(negedge clk);
    check("add_retired", retired, 32'd1);
    check("add_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill both entries, third op must wait.
    out_ready = 1'b0;
    drive(4'd1, 32'd10, 32'd3, 5'd1);
    @(negedge clk);
    check("bp_ready_1", {31'd0, in_ready}, 32'd1);
    drive(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd2);
    @(negedge clk);
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    drive(4'd2, 32'hF0, 32'h3C, 5'd4);
    @(negedge clk);
    check("bp_held_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head_stable", out_data, 32'd7);
    out_ready = 1'b1;
    @(negedge clk);
    exp_retired++;
    check("bp_second", out_data, 32'd1);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    exp_retired++;
    in_valid = 1'b0;
    check("bp_third", out_data, 32'h30);
    check("bp_third_rd", {27'd0, out_rd}, 32'd4);
    @(negedge clk);
    exp_retired++;
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_retired", retired, exp_retired);

    // Shifts, illegal code and rd=0.
    single_op("sra", 4'd9, 32'h8000_0000, 32'h24, 5'd5, 32'hF800_0000, 1'b1, 1'b0);
    single_op("sll", 4'd7, 32'd1, 32'h3F, 5'd6, 32'h8000_0000, 1'b1, 1'b0);
    single_op("ill", 4'd12, 32'h1234, 32'h5678, 5'd7, 32'd0, 1'b0, 1'b1);
    single_op("rd0", 4'd4, 32'hFF, 32'h0F, 5'd0, 32'hF0, 1'b0, 1'b0);
    single_op("sltu", 4'd6, 32'd1, 32'hFFFF_FFFF, 5'd8, 32'd1, 1'b1, 1'b0);
    single_op("copy1", 4'd10, 32'hDEAD_BEEF, 32'd0, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Streaming 100 random ops with random backpressure.
    begin
      int   sent   = 0;
      int   recv   = 0;
      int   cycles = 0;
      logic taken;
      exp_t e;
      exp_t h;
      in_valid = 1'b0;
      while (recv < 100 && cycles < 5000) begin
        @(negedge clk);
        cycles++;
        if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
          drive(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
        end
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("stream_spurious", {31'd0, out_valid}, 32'd0);
          end else begin
            h = sb.pop_front();
            check("stream_data", out_data, h.data);
            check("stream_tag", {25'd0, out_rd, out_wen, out_illegal},
                  {25'd0, h.rd, h.wen, h.illegal});
          end
          recv++;
          exp_retired++;
        end
        taken = in_valid && in_ready;
        if (taken) begin
          e.data    = ref_alu(in_sel, in_op1, in_op2);
          e.rd      = in_rd;
          e.illegal = (in_sel > 4'd10);
          e.wen     = (in_rd != 5'd0) && !e.illegal;
          sb.push_back(e);
          sent++;
        end
        @(posedge clk);
        #1;
        if (taken) in_valid = 1'b0;
      end
      check("stream_timeout", {31'd0, (cycles >= 5000)}, 32'd0);
      @(negedge clk);
      check("stream_retired", retired, exp_retired);
      check("stream_sb_empty", sb.size(), 32'd0);
    end

    // Reset with two entries buffered.
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd1, 5'd1);
    @(negedge clk);
    drive(4'd0, 32'd2, 32'd2, 5'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(4'd3, 32'hA0, 32'h05, 5'd10);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_data", out_data, 32'hA5);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("post_rst_only_one", {31'd0, out_valid}, 32'd0);
    check("post_rst_retired", retired, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
